out_port_uart_tx: RTL and testbench

Serial transmitter for the memory-mapped output word that the memory unit exposes from its top address. It watches the parallel output word every cycle and captures each new value. It then sends that value as an asynchronous serial frame: one start bit, WIDTH data bits LSB first, one stop bit. It sits directly downstream of the memory unit and is the CPU's only observable output off-chip.

---
 rtl/out_port_uart_tx.sv | 144 ++++++++++++++
 tb/tb_out_port_uart_tx.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/out_port_uart_tx.sv
// Serial transmitter for the memory-mapped output word.
// Captures every change of OUT_IN into a one-deep holding register and sends
// it as a frame: start bit (0), WIDTH data bits LSB first, stop bit (1).
//
//   state   | meaning
//   --------+-----------------------------------------------
//   S_IDLE  | line high, waiting for a pending value
//   S_START | start bit, line low for CLKS_PER_BIT cycles
//   S_DATA  | data bits, shift[0] on the line
//   S_STOP  | stop bit, line high for CLKS_PER_BIT cycles
module out_port_uart_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] OUT_IN,
    input  logic             CLEAR_OVERRUN,
    output logic             TX,
    output logic             BUSY,
    output logic             OVERRUN
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] hold, hold_nx;
    logic [WIDTH-1:0] shift, shift_nx;
    logic             pend, pend_nx;
    logic [BW-1:0]    bitcnt, bitcnt_nx;
    logic [CW-1:0]    clkcnt, clkcnt_nx;
    logic             ovr_nx;
    logic             tx_nx;
    logic             change;
    logic             consume;
    logic             clk_last;

    assign change   = (OUT_IN != prev);
    assign consume  = (state == S_IDLE) && pend;
    assign clk_last = (clkcnt == CLK_LAST);
    assign BUSY     = (state != S_IDLE) || pend;

    // Change detect, one-deep buffer and sticky overrun; a same-edge consume
    // hands the old hold to the shifter so the new value is not an overrun.
    always_comb begin
        hold_nx = hold;
        pend_nx = pend;
        if (change) begin
            hold_nx = OUT_IN;
            pend_nx = 1'b1;
        end else if (consume) begin
            pend_nx = 1'b0;
        end
        ovr_nx = (OVERRUN && !CLEAR_OVERRUN) || (change && pend && !consume);
    end

    // Frame sequencer; TX is computed from the next state so the line is registered.
    always_comb begin
        state_nx  = state;
        shift_nx  = shift;
        bitcnt_nx = bitcnt;
        clkcnt_nx = clkcnt;
        tx_nx     = 1'b1;
        case (state)
            S_IDLE: begin
                if (pend) begin
                    state_nx  = S_START;
                    shift_nx  = hold;
                    clkcnt_nx = '0;
                    tx_nx     = 1'b0;
                end
            end
            S_START: begin
                tx_nx = 1'b0;
                if (clk_last) begin
                    state_nx  = S_DATA;
                    bitcnt_nx = '0;
                    clkcnt_nx = '0;
                    tx_nx     = shift[0];
                end else begin
                    clkcnt_nx = clkcnt + CW'(1);
                end
            end
            S_DATA: begin
                tx_nx = shift[0];
                if (clk_last) begin
                    clkcnt_nx = '0;
                    if (bitcnt == BIT_LAST) begin
                        state_nx = S_STOP;
                        tx_nx    = 1'b1;
                    end else begin
                        shift_nx  = shift >> 1;
                        bitcnt_nx = bitcnt + BW'(1);
                        tx_nx     = shift_nx[0];
                    end
                end else begin
                    clkcnt_nx = clkcnt + CW'(1);
                end
            end
            S_STOP: begin
                tx_nx = 1'b1;
                if (clk_last) begin
                    state_nx  = S_IDLE;
                    clkcnt_nx = '0;
                end else begin
                    clkcnt_nx = clkcnt + CW'(1);
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // State and datapath registers; reset forces the line high at once.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state   <= S_IDLE;
            prev    <= '0;
            hold    <= '0;
            pend    <= 1'b0;
            shift   <= '0;
            bitcnt  <= '0;
            clkcnt  <= '0;
            OVERRUN <= 1'b0;
            TX      <= 1'b1;
        end else begin
            state   <= state_nx;
            prev    <= OUT_IN;
            hold    <= hold_nx;
            pend    <= pend_nx;
            shift   <= shift_nx;
            bitcnt  <= bitcnt_nx;
            clkcnt  <= clkcnt_nx;
            OVERRUN <= ovr_nx;
            TX      <= tx_nx;
        end
    end

endmodule

// File: tb/tb_out_port_uart_tx.sv
// Testbench for out_port_uart_tx with a frame-level reference model.
module tb_out_port_uart_tx;

    localparam int W  = 8;
    localparam int C  = 4;
    localparam int FL = (W + 2) * C;

    logic         CLOCK = 1'b0;
    logic         RESET = 1'b0;
    logic [W-1:0] OUT_IN = '0;
    logic         CLEAR_OVERRUN = 1'b0;
    logic         TX, BUSY, OVERRUN;

    int n_tests = 0;
    int n_fail  = 0;

    out_port_uart_tx #(.WIDTH(W), .CLKS_PER_BIT(C)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .OUT_IN(OUT_IN), .CLEAR_OVERRUN(CLEAR_OVERRUN),
        .TX(TX), .BUSY(BUSY), .OVERRUN(OVERRUN)
    );

    always #5 CLOCK = ~CLOCK;

    // Reference model: last seen word, one waiting word, sticky overrun, and the
    // frame on the line as a bit pattern plus elapsed cycles (-1 = line idle).
    logic [W-1:0] m_prev, m_hold;
    logic         m_pend, m_ovr;
    logic [W+1:0] m_frame;
    int           m_t;

    function automatic void model_reset();
        m_prev = '0; m_hold = '0; m_pend = 1'b0; m_ovr = 1'b0;
        m_frame = '1; m_t = -1;
    endfunction

    function automatic void model_edge();
        logic chg, idle_before, take;
        chg         = (OUT_IN != m_prev);
        idle_before = (m_t < 0);
        take        = idle_before && m_pend;
        if (m_t >= 0) begin
            m_t = m_t + 1;
            if (m_t == FL) m_t = -1;
        end
        if (take) begin
            m_frame = {1'b1, m_hold, 1'b0};
            m_t = 0;
        end
        if (CLEAR_OVERRUN) m_ovr = 1'b0;
        if (chg && m_pend && !take) m_ovr = 1'b1;
        if (chg) begin
            m_hold = OUT_IN;
            m_pend = 1'b1;
        end else if (take) begin
            m_pend = 1'b0;
        end
        m_prev = OUT_IN;
    endfunction

    function automatic logic exp_tx();
        return (m_t < 0) ? 1'b1 : m_frame[m_t / C];
    endfunction

    function automatic logic exp_busy();
        return (m_t >= 0) || m_pend;
    endfunction

    task automatic step();
        @(posedge CLOCK);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        int fall_at;
        RESET = 1'b0; OUT_IN = 8'hFF; CLEAR_OVERRUN = 1'b0;
        model_reset();
        repeat (2) @(posedge CLOCK);
        #1;
        n_tests++;
        if ({TX, BUSY, OVERRUN} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_hold tx/busy/ovr=%b%b%b want 100", TX, BUSY, OVERRUN);
        end
        RESET = 1'b1;
        fall_at = -1;
        for (int i = 0; i < FL + 6; i++) begin
            step();
            if (TX === 1'b0 && fall_at < 0) fall_at = i;
            n_tests++;
            if ({TX, BUSY, OVERRUN} !== {exp_tx(), exp_busy(), m_ovr}) begin
                n_fail++;
                $display("FAIL reset_release cyc=%0d tx/busy/ovr=%b%b%b want %b%b%b",
                         i, TX, BUSY, OVERRUN, exp_tx(), exp_busy(), m_ovr);
            end
        end
        n_tests++;
        if (fall_at !== 1) begin
            n_fail++;
            $display("FAIL reset_first_fall edge=%0d want 1", fall_at);
        end
    endtask

    task automatic test_single();
        OUT_IN = 8'h00;
        for (int i = 0; i < FL + 5; i++) begin
            step();
            n_tests++;
            if ({TX, BUSY, OVERRUN} !== {exp_tx(), exp_busy(), m_ovr}) begin
                n_fail++;
                $display("FAIL single_zero cyc=%0d tx/busy/ovr=%b%b%b want %b%b%b",
                         i, TX, BUSY, OVERRUN, exp_tx(), exp_busy(), m_ovr);
            end
        end
        OUT_IN = 8'hA5;
        for (int i = 0; i < FL + 25; i++) begin
            step();
            n_tests++;
            if ({TX, BUSY, OVERRUN} !== {exp_tx(), exp_busy(), m_ovr}) begin
                n_fail++;
                $display("FAIL single_a5 cyc=%0d tx/busy/ovr=%b%b%b want %b%b%b",
                         i, TX, BUSY, OVERRUN, exp_tx(), exp_busy(), m_ovr);
            end
        end
        n_tests++;
        if ({TX, BUSY} !== 2'b10) begin
            n_fail++;
            $display("FAIL no_resend tx/busy=%b%b want 10", TX, BUSY);
        end
    endtask

    task automatic test_back_to_back();
        OUT_IN = 8'h01;
        for (int i = 0; i < 2 * FL + 20; i++) begin
            if (i == 10) OUT_IN = 8'h02;
            step();
            n_tests++;
            if ({TX, BUSY, OVERRUN} !== {exp_tx(), exp_busy(), m_ovr}) begin
                n_fail++;
                $display("FAIL back_to_back cyc=%0d tx/busy/ovr=%b%b%b want %b%b%b",
                         i, TX, BUSY, OVERRUN, exp_tx(), exp_busy(), m_ovr);
            end
        end
    endtask

    task automatic test_overrun();
        OUT_IN = 8'h10;
        for (int i = 0; i < 2 * FL + 30; i++) begin
            if (i == 8)  OUT_IN = 8'h20;
            if (i == 11) OUT_IN = 8'h30;
            CLEAR_OVERRUN = (i == 2 * FL + 20);
            step();
            n_tests++;
            if ({TX, BUSY, OVERRUN} !== {exp_tx(), exp_busy(), m_ovr}) begin
                n_fail++;
                $display("FAIL overrun cyc=%0d tx/busy/ovr=%b%b%b want %b%b%b",
                         i, TX, BUSY, OVERRUN, exp_tx(), exp_busy(), m_ovr);
            end
        end
        n_tests++;
        if (OVERRUN !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_cleared ovr=%b want 0", OVERRUN);
        end
        OUT_IN = 8'h40;
        for (int i = 0; i < 2 * FL + 10; i++) begin
            if (i == 4) OUT_IN = 8'h50;
            if (i == 8) begin OUT_IN = 8'h60; CLEAR_OVERRUN = 1'b1; end
            else CLEAR_OVERRUN = 1'b0;
            step();
            n_tests++;
            if ({TX, BUSY, OVERRUN} !== {exp_tx(), exp_busy(), m_ovr}) begin
                n_fail++;
                $display("FAIL overrun_clear_same cyc=%0d tx/busy/ovr=%b%b%b want %b%b%b",
                         i, TX, BUSY, OVERRUN, exp_tx(), exp_busy(), m_ovr);
            end
            if (i == 8) begin
                n_tests++;
                if (OVERRUN !== 1'b1) begin
                    n_fail++;
                    $display("FAIL set_wins ovr=%b want 1", OVERRUN);
                end
            end
        end
        CLEAR_OVERRUN = 1'b1;
        step();
        CLEAR_OVERRUN = 1'b0;
    endtask

    task automatic test_reset_mid();
        OUT_IN = 8'hF7;
        // change edge + start edge put bit 3 of the data at frame cycles 16..19
        for (int i = 0; i < 19; i++) begin
            step();
            n_tests++;
            if ({TX, BUSY, OVERRUN} !== {exp_tx(), exp_busy(), m_ovr}) begin
                n_fail++;
                $display("FAIL pre_reset cyc=%0d tx/busy/ovr=%b%b%b want %b%b%b",
                         i, TX, BUSY, OVERRUN, exp_tx(), exp_busy(), m_ovr);
            end
        end
        #2;
        RESET = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if ({TX, BUSY, OVERRUN} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_async tx/busy/ovr=%b%b%b want 100", TX, BUSY, OVERRUN);
        end
        OUT_IN = 8'h00;
        @(posedge CLOCK);
        #1;
        RESET = 1'b1;
        for (int i = 0; i < FL + 5; i++) begin
            step();
            n_tests++;
            if ({TX, BUSY, OVERRUN} !== 3'b100 ||
                {TX, BUSY, OVERRUN} !== {exp_tx(), exp_busy(), m_ovr}) begin
                n_fail++;
                $display("FAIL post_reset_quiet cyc=%0d tx/busy/ovr=%b%b%b want 100", i, TX, BUSY, OVERRUN);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 11) == 0) OUT_IN = W'($urandom_range(0, 255));
            CLEAR_OVERRUN = ($urandom_range(0, 19) == 0);
            step();
            n_tests++;
            if ({TX, BUSY, OVERRUN} !== {exp_tx(), exp_busy(), m_ovr}) begin
                n_fail++;
                $display("FAIL random cyc=%0d tx/busy/ovr=%b%b%b want %b%b%b",
                         i, TX, BUSY, OVERRUN, exp_tx(), exp_busy(), m_ovr);
            end
        end
        CLEAR_OVERRUN = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
